// File: rtl/cr_unit.sv
// Condition-register unit: executes CR logical ops, mcrf and record writes through a
// 1-cycle valid/ready result pipe, with a field-masked mtcrf port that always wins.
module cr_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op,
  input  logic [4:0]  ba,
  input  logic [4:0]  bb,
  input  logic [4:0]  bt,
  input  logic [2:0]  bfa,
  input  logic [2:0]  bf,
  input  logic [3:0]  rec_field,
  input  logic        mtcrf_we,
  input  logic [7:0]  mtcrf_mask,
  input  logic [31:0] mtcrf_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_cr,
  output logic [31:0] cr
);

  typedef enum logic [3:0] {
    OP_CRAND  = 4'd0,
    OP_CRANDC = 4'd1,
    OP_CROR   = 4'd2,
    OP_CRORC  = 4'd3,
    OP_CRXOR  = 4'd4,
    OP_CRNAND = 4'd5,
    OP_CRNOR  = 4'd6,
    OP_CREQV  = 4'd7,
    OP_MCRF   = 4'd8,
    OP_RECORD = 4'd9
  } op_e;

  logic [31:0] cr_q;
  logic [31:0] res_q;
  logic        res_valid_q;

  logic        accept;
  logic [4:0]  pos_a, pos_b, pos_t, pos_fa, pos_f;
  logic        bit_a, bit_b, bit_t;
  logic [31:0] op_cr;
  logic [31:0] mask_bits;
  logic [31:0] next_cr;

  assign op_ready = !res_valid_q || res_ready;
  assign accept   = op_valid && op_ready;

  // Power numbering: bit 0 is the MSB, field 0 is the top nibble.
  assign pos_a  = 5'd31 - ba;
  assign pos_b  = 5'd31 - bb;
  assign pos_t  = 5'd31 - bt;
  assign pos_fa = 5'd31 - {bfa, 2'b00};
  assign pos_f  = 5'd31 - {bf, 2'b00};

  assign bit_a = cr_q[pos_a];
  assign bit_b = cr_q[pos_b];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bit_t = 1'b0;
    case (op_e'(op))
      OP_CRAND:  bit_t = bit_a & bit_b;
      OP_CRANDC: bit_t = bit_a & ~bit_b;
      OP_CROR:   bit_t = bit_a | bit_b;
      OP_CRORC:  bit_t = bit_a | ~bit_b;
      OP_CRXOR:  bit_t = bit_a ^ bit_b;
      OP_CRNAND: bit_t = ~(bit_a & bit_b);
      OP_CRNOR:  bit_t = ~(bit_a | bit_b);
      OP_CREQV:  bit_t = ~(bit_a ^ bit_b);
      default:   bit_t = 1'b0;
    endcase
  end

  // Operation result alone; reserved codes fall through and leave the CR untouched.
  always_comb begin
    op_cr = cr_q;
    if (!op[3])
      op_cr[pos_t] = bit_t;
    else if (op == OP_MCRF)
      op_cr[pos_f -: 4] = cr_q[pos_fa -: 4];
    else if (op == OP_RECORD)
      op_cr[pos_f -: 4] = rec_field;
  end

  always_comb begin
    mask_bits = '0;
    for (int f = 0; f < 8; f++)
      mask_bits[31-4*f -: 4] = {4{mtcrf_mask[7-f]}};
  end

  // mtcrf is merged last so it overrides the operation on overlapping fields.
  always_comb begin
    next_cr = accept ? op_cr : cr_q;
    if (mtcrf_we)
      next_cr = (next_cr & ~mask_bits) | (mtcrf_data & mask_bits);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cr_q        <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      cr_q <= next_cr;
      if (accept) begin
        res_valid_q <= 1'b1;
        res_q       <= op_cr;
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign cr        = cr_q;
  assign res_cr    = res_q;
  assign res_valid = res_valid_q;

endmodule

// File: doc/cr_unit.md
CR_UNIT -- requirements
Module: cr_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port op_valid, input, 1 bit: a CR operation is offered.
REQ-004 The block SHALL have the port op_ready, output, 1 bit: the block can accept an operation this cycle.
REQ-005 The block SHALL have the port op, input, 4 bits, with encodings 0 crand, 1 crandc, 2 cror, 3 crorc, 4 crxor, 5 crnand, 6 crnor, 7 creqv, 8 mcrf, 9 record; codes 10-15 are reserved.
REQ-006 The block SHALL have the ports ba, bb and bt, input, 5 bits each: source A, source B and target CR bit indices.
REQ-007 The block SHALL have the ports bfa and bf, input, 3 bits each: source and target field indices for mcrf and record.
REQ-008 The block SHALL have the port rec_field, input, 4 bits {lt,gt,eq,so}: a field produced by an execution unit, written by the record operation.
REQ-009 The block SHALL have the ports mtcrf_we, input, 1 bit; mtcrf_mask, input, 8 bits; and mtcrf_data, input, 32 bits: a direct field-masked write port.
REQ-010 The block SHALL have the ports res_valid, output, 1 bit, and res_ready, input, 1 bit: the result handshake.
REQ-011 The block SHALL have the port res_cr, output, 32 bits: a snapshot of the CR immediately after the completed operation.
REQ-012 The block SHALL have the port cr, output, 32 bits: the current architectural CR.

Function
REQ-013 CR bit i, using Power numbering 0 = MSB, SHALL map to cr[31-i]; field f SHALL occupy cr[31-4f -: 4] in the order lt,gt,eq,so.
REQ-014 op_ready SHALL be computed combinationally as !res_valid || res_ready.
REQ-015 An operation SHALL be accepted on a rising edge where op_valid && op_ready.
REQ-016 On the accepting edge, the CR register and the result register SHALL update together, giving a latency of 1 cycle: res_valid is high from the next cycle on.
REQ-017 For the bit ops (codes 0-7), CR[bt] SHALL be set to f(CR[ba], CR[bb]), where f is and, a&~b, or, a|~b, xor, ~(a&b), ~(a|b) or ~(a^b) respectively; all other bits are unchanged.
REQ-018 mcrf SHALL set field bf to the value of field bfa; bf == bfa leaves the CR unchanged.
REQ-019 record SHALL set field bf to rec_field.
REQ-020 A reserved op SHALL be accepted, SHALL leave the CR unchanged, and SHALL still produce a result with res_cr equal to the unchanged CR.
REQ-021 The sources of an operation SHALL be the CR register value at the accepting edge; because that value already includes the previous operation's update, back-to-back dependent operations need no stall.
REQ-022 res_valid and res_cr SHALL hold stable while res_valid && !res_ready.
REQ-023 res_valid SHALL clear on an edge where res_ready is high and no new operation is accepted.
REQ-024 When an operation is accepted in the same cycle that res_valid && res_ready, res_valid SHALL stay high and res_cr SHALL be replaced by the new result, giving full throughput of 1 operation per cycle.
REQ-025 mtcrf_we SHALL be accepted unconditionally, independent of the handshakes.
REQ-026 On an mtcrf write, for each set bit mtcrf_mask[7-f], field f SHALL load mtcrf_data[31-4f -: 4].
REQ-027 When an mtcrf write and an accepted operation occur in the same cycle:
- the operation SHALL read the pre-edge CR;
- both updates SHALL be applied;
- on overlapping bits, mtcrf SHALL take priority;
- res_cr SHALL reflect the operation's update only, excluding the mtcrf write.
REQ-028 cr SHALL always show the registered CR value; there SHALL be no combinational path from the inputs to cr or res_cr.

Reset
REQ-029 While reset is high, cr, res_cr and res_valid SHALL be 0 asynchronously, and op_ready SHALL be 1.
REQ-030 Reset asserted mid-handshake SHALL discard a pending result.
REQ-031 After reset deasserts, the first rising edge SHALL be able to accept an operation.

Verification
REQ-032 Scenario, record: reset; then record with bf=0 and rec_field=4'b1000 -> the next cycle shows cr=32'h8000_0000, res_valid=1 and res_cr=32'h8000_0000.
REQ-033 Scenario, dependent back-to-back bit ops: from cr=32'h8000_0000, issue cror bt=1 ba=0 bb=2 and then, on the next cycle, crand bt=2 ba=0 bb=1, with res_ready=1 -> cr=32'hC000_0000 and then 32'hE000_0000 on consecutive cycles.
REQ-034 Scenario, backpressure: hold res_ready=0 for 3 cycles after one operation -> op_ready=0, res_cr stable, and a second offered operation is not accepted until res_ready=1.
REQ-035 Scenario, mcrf: from cr=32'hA000_0000, issue mcrf bf=7 bfa=0 -> cr=32'hA000_000A.
REQ-036 Scenario, collision: in the same cycle, issue crxor bt=0 ba=0 bb=0 and mtcrf mask=8'h80 data=32'h5000_0000 -> cr[31:28]=4'b0101, and res_cr[31]=0.
REQ-037 Scenario, reset mid-transfer: assert reset while res_valid=1 and res_ready=0 -> res_valid=0 and cr=0 immediately, without waiting for a clock edge.
